// File: rtl/riscv_defines.sv
// Shared definitions for the data-memory responder: FSM states and parameter limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defines;

  // Handshake FSM states of the data-memory responder
  typedef enum logic [1:0] {
    DMEM_IDLE      = 2'd0,
    DMEM_GNT_WAIT  = 2'd1,
    DMEM_RESP_WAIT = 2'd2
  } dmem_state_t;

  // Upper limits for the responder's timing parameters
  localparam int DMEM_RESP_LAT_MAX = 15;
  localparam int DMEM_GNT_WAIT_MAX = 15;

endpackage

// File: rtl/riscv_dmem_array.sv
// Word-addressed 32-bit storage with per-byte write enables; contents are never reset.
// Latency: write commits on the enabling edge; read word is registered on that same edge.
// Backpressure: none; accepts one access whenever en is high.
module riscv_dmem_array #(
  parameter int WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane write, or capture of the full addressed word for a read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for the core LSU data bus (req/gnt/rvalid), backed by riscv_dmem_array.
// Latency: grant GNT_WAIT cycles after req rises; rvalid RESP_LAT cycles after the grant edge.
// Backpressure: one transfer outstanding; a new grant only when idle or in the rvalid cycle.
module riscv_dmem_responder
  import riscv_defines::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          GNT_WAIT  = 0,
  parameter int          RESP_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0]  GW        = 4'(GNT_WAIT);
  localparam logic [3:0]  RL        = 4'(RESP_LAT);
  localparam logic [32:0] SPAN      = 33'(MEM_WORDS) * 33'd4;

  if (GNT_WAIT < 0 || GNT_WAIT > DMEM_GNT_WAIT_MAX) begin : g_bad_gnt_wait
    $error("riscv_dmem_responder: GNT_WAIT out of range");
  end
  if (RESP_LAT < 1 || RESP_LAT > DMEM_RESP_LAT_MAX) begin : g_bad_resp_lat
    $error("riscv_dmem_responder: RESP_LAT out of range");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("riscv_dmem_responder: MEM_WORDS must be a power of two");
  end

  dmem_state_t      state;
  logic [3:0]       wait_cnt;
  logic [3:0]       resp_cnt;
  logic             rvalid_q;
  logic             resp_err;
  logic             resp_rd;
  logic [32:0]      off_ext;
  logic             req_err;
  logic [IDX_W-1:0] word_idx;
  logic             accept;
  logic [31:0]      arr_rdata;

  // Range/alignment/enable check; a borrow out of the 33-bit subtraction means below BASE_ADDR.
  // The word index is only meaningful (and only used) once the range check has passed.
  always_comb begin
    off_ext  = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    req_err  = off_ext[32] | (off_ext >= SPAN) | (data_addr_i[1:0] != 2'b00) | (data_be_i == 4'b0000);
    word_idx = IDX_W'(off_ext >> 2);
  end

  // Grant once the wait count is met and the single response slot is free or freeing this cycle
  assign data_gnt_o = rst_n & data_req_i & (wait_cnt == GW) &
                      ((state != DMEM_RESP_WAIT) | rvalid_q);
  assign accept     = data_req_i & data_gnt_o;

  riscv_dmem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (accept & ~req_err),
    .we    (data_we_i),
    .be    (data_be_i),
    .idx   (word_idx),
    .wdata (data_wdata_i),
    .rdata (arr_rdata)
  );

  // Handshake FSM: grant wait counting, response latency countdown and registered rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DMEM_IDLE;
      wait_cnt <= 4'd0;
      resp_cnt <= 4'd0;
      rvalid_q <= 1'b0;
      resp_err <= 1'b0;
      resp_rd  <= 1'b0;
    end else begin
      if (!data_req_i || accept) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != GW) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (accept) begin
        state    <= DMEM_RESP_WAIT;
        resp_cnt <= RL - 4'd1;
        rvalid_q <= (RESP_LAT == 1);
        resp_err <= req_err;
        resp_rd  <= ~data_we_i;
      end else begin
        case (state)
          DMEM_IDLE: begin
            if (data_req_i && (GW != 4'd0)) state <= DMEM_GNT_WAIT;
          end
          DMEM_GNT_WAIT: begin
            if (!data_req_i) state <= DMEM_IDLE;
          end
          DMEM_RESP_WAIT: begin
            if (rvalid_q) begin
              rvalid_q <= 1'b0;
              state    <= DMEM_IDLE;
            end else begin
              resp_cnt <= resp_cnt - 4'd1;
              rvalid_q <= (resp_cnt == 4'd1);
            end
          end
          default: state <= DMEM_IDLE;
        endcase
      end
    end
  end

  // Response data/error are forced to zero outside the rvalid strobe and for writes/errors
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = rvalid_q & resp_err;
  assign data_rdata_o  = (rvalid_q && resp_rd && !resp_err) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: three instances with different grant/response timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [2:0]  rst_n, req, we, gnt, rvalid, err;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be [3];

  int gw_of  [3] = '{0, 3, 0};
  int lat_of [3] = '{1, 2, 3};

  logic [31:0] mref [3][16];
  int tests_run = 0;
  int tests_failed = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_dmem_responder #(
      .BASE_ADDR (32'h0000_0000),
      .MEM_WORDS (1024),
      .GNT_WAIT  ((g == 1) ? 3 : 0),
      .RESP_LAT  ((g == 0) ? 1 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .data_req_i    (req[g]),
      .data_gnt_o    (gnt[g]),
      .data_addr_i   (addr[g]),
      .data_we_i     (we[g]),
      .data_be_i     (be[g]),
      .data_wdata_i  (wdata[g]),
      .data_rvalid_o (rvalid[g]),
      .data_rdata_o  (rdata[g]),
      .data_err_o    (err[g])
    );
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // One transfer: reports grant latency, response latency, response fields and a count of
  // protocol anomalies (rvalid before grant, nonzero idle outputs, rvalid longer than a cycle).
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, output int lat_g, output int lat_r,
                      output logic [31:0] rd, output logic e, output int bad);
    int t0, gc;
    gc = -1; lat_g = -1; lat_r = -1; rd = 32'h0; e = 1'b0; bad = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd; t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rvalid[d] !== 1'b0) bad++;
      if (gnt[d] === 1'b1) begin gc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req[d] = 1'b0;
    if (gc >= 0) begin
      lat_g = gc - t0;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (rvalid[d] === 1'b1) begin lat_r = cyc - gc; rd = rdata[d]; e = err[d]; break; end
        if (rdata[d] !== 32'h0 || err[d] !== 1'b0) bad++;
        @(negedge clk);
      end
      @(negedge clk); #1;
      if (rvalid[d] !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (gnt[d] !== 1'b0 || rvalid[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: gnt=%b rvalid=%b err=%b rdata=%h, want all 0",
                 d, gnt[d], rvalid[d], err[d], rdata[d]);
      end
    end
    @(negedge clk); req = 3'b000;
    @(negedge clk); rst_n = 3'b111;
  endtask

  task automatic test_basic();
    int lg, lr, bad; logic [31:0] rd; logic e;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF; #1;
    tests_run++;
    if (gnt[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_wr_gnt: gnt=%b rvalid=%b, want 1 0", gnt[0], rvalid[0]);
    end
    @(negedge clk);
    we[0] = 1'b0; wdata[0] = 32'h0; #1;
    tests_run++;
    if (gnt[0] !== 1'b1 || rvalid[0] !== 1'b1 || err[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_rd_gnt_wr_resp: gnt=%b rvalid=%b err=%b rdata=%h, want 1 1 0 0",
               gnt[0], rvalid[0], err[0], rdata[0]);
    end
    @(negedge clk);
    req[0] = 1'b0; #1;
    tests_run++;
    if (rvalid[0] !== 1'b1 || err[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL basic_rd_resp: rvalid=%b err=%b rdata=%h, want 1 0 deadbeef", rvalid[0], err[0], rdata[0]);
    end
    @(negedge clk); #1;
    tests_run++;
    if (rvalid[0] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_rvalid_end: rvalid=%b, want 0", rvalid[0]);
    end
    xfer(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, lg, lr, rd, e, bad);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lg, lr, rd, e, bad);
    tests_run++;
    if (rd !== 32'hDEADBEAA || e !== 1'b0 || lg !== 0 || lr !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL byte_lane_write: rdata=%h err=%b lat_g=%0d lat_r=%0d bad=%0d, want deadbeaa 0 0 1 0",
               rd, e, lg, lr, bad);
    end
    mref[0][4] = 32'hDEADBEAA;
  endtask

  task automatic test_errors();
    int lg, lr, bad; logic [31:0] rd; logic e;
    logic [31:0] ea [4] = '{32'h1000, 32'h2, 32'h10, 32'h1010};
    logic        ew [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  eb [4] = '{4'hF, 4'hF, 4'h0, 4'hF};
    for (int k = 0; k < 4; k++) begin
      xfer(0, ew[k], ea[k], eb[k], 32'h12345678, lg, lr, rd, e, bad);
      tests_run++;
      if (e !== 1'b1 || rd !== 32'h0 || lg !== 0 || lr !== 1 || bad !== 0) begin
        tests_failed++;
        $display("FAIL err_case%0d addr=%h: err=%b rdata=%h lat_g=%0d lat_r=%0d bad=%0d, want 1 0 0 1 0",
                 k, ea[k], e, rd, lg, lr, bad);
      end
    end
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lg, lr, rd, e, bad);
    tests_run++;
    if (rd !== mref[0][4] || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_mem_unchanged: rdata=%h err=%b, want %h 0", rd, e, mref[0][4]);
    end
  endtask

  task automatic test_back_to_back();
    int lg, lr, bad, g_cnt, r_cnt, d_bad; logic [31:0] rd; logic e;
    for (int k = 0; k < 8; k++) begin
      mref[0][8+k] = $urandom;
      xfer(0, 1'b1, 32'((8 + k) * 4), 4'hF, mref[0][8+k], lg, lr, rd, e, bad);
    end
    g_cnt = 0; r_cnt = 0; d_bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'((8 + k) * 4); be[0] = 4'($urandom_range(1, 15)); #1;
      if (gnt[0] === 1'b1) g_cnt++;
      if (k > 0 && rvalid[0] === 1'b1) begin
        r_cnt++;
        if (rdata[0] !== mref[0][7+k] || err[0] !== 1'b0) d_bad++;
      end
    end
    @(negedge clk);
    req[0] = 1'b0; #1;
    if (rvalid[0] === 1'b1) begin
      r_cnt++;
      if (rdata[0] !== mref[0][15] || err[0] !== 1'b0) d_bad++;
    end
    tests_run++;
    if (g_cnt !== 8 || r_cnt !== 8 || d_bad !== 0) begin
      tests_failed++;
      $display("FAIL back_to_back: grants=%0d rvalids=%0d data_errs=%0d, want 8 8 0", g_cnt, r_cnt, d_bad);
    end
    @(negedge clk); #1;
    tests_run++;
    if (rvalid[0] !== 1'b0) begin
      tests_failed++; $display("FAIL back_to_back_tail: rvalid=%b, want 0", rvalid[0]);
    end
  endtask

  task automatic test_gnt_wait();
    int lg, lr, bad, early; logic [31:0] rd; logic e;
    mref[1][0] = $urandom;
    xfer(1, 1'b1, 32'h0, 4'hF, mref[1][0], lg, lr, rd, e, bad);
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, lg, lr, rd, e, bad);
    tests_run++;
    if (lg !== 3 || lr !== 2 || bad !== 0 || rd !== mref[1][0] || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL gnt_wait_read: lat_g=%0d lat_r=%0d bad=%0d rdata=%h err=%b, want 3 2 0 %h 0",
               lg, lr, bad, rd, e, mref[1][0]);
    end
    // a request that drops before its grant must restart the wait from zero
    early = 0;
    @(negedge clk); req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; be[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #1; if (gnt[1] !== 1'b0) early++;
      @(negedge clk);
    end
    req[1] = 1'b0;
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, lg, lr, rd, e, bad);
    tests_run++;
    if (early !== 0 || lg !== 3 || lr !== 2 || bad !== 0) begin
      tests_failed++;
      $display("FAIL gnt_wait_restart: early=%0d lat_g=%0d lat_r=%0d bad=%0d, want 0 3 2 0", early, lg, lr, bad);
    end
  endtask

  task automatic test_reset_mid();
    int lg, lr, bad, stray; logic [31:0] rd; logic e;
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0; be[2] = 4'hF; #1;
    tests_run++;
    if (gnt[2] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_gnt: gnt=%b, want 1", gnt[2]); end
    @(negedge clk);
    req[2] = 1'b0; rst_n[2] = 1'b0; #1;
    tests_run++;
    if (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: gnt=%b rvalid=%b err=%b rdata=%h, want all 0", gnt[2], rvalid[2], err[2], rdata[2]);
    end
    @(negedge clk); req[2] = 1'b1; #1;
    tests_run++;
    if (gnt[2] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_gnt_in_reset: gnt=%b, want 0", gnt[2]); end
    @(negedge clk); req[2] = 1'b0; rst_n[2] = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      #1; if (rvalid[2] !== 1'b0) stray++;
      @(negedge clk);
    end
    tests_run++;
    if (stray !== 0) begin tests_failed++; $display("FAIL rstmid_discard: stray rvalids=%0d, want 0", stray); end
    mref[2][1] = $urandom;
    xfer(2, 1'b1, 32'h4, 4'hF, mref[2][1], lg, lr, rd, e, bad);
    xfer(2, 1'b0, 32'h4, 4'hF, 32'h0, lg, lr, rd, e, bad);
    tests_run++;
    if (lg !== 0 || lr !== 3 || bad !== 0 || rd !== mref[2][1] || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_after: lat_g=%0d lat_r=%0d bad=%0d rdata=%h err=%b, want 0 3 0 %h 0",
               lg, lr, bad, rd, e, mref[2][1]);
    end
  endtask

  task automatic test_random(input int d, input int n);
    int lg, lr, bad, kind; logic [31:0] rd, a, wd, exp_rd; logic e, w, exp_e; logic [3:0] b;
    for (int k = 0; k < 16; k++) begin
      mref[d][k] = $urandom;
      xfer(d, 1'b1, 32'(k * 4), 4'hF, mref[d][k], lg, lr, rd, e, bad);
    end
    for (int t = 0; t < n; t++) begin
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (kind == 0) a = 32'h1000 + a;
      if (kind == 1) a = a | 32'($urandom_range(1, 3));
      b = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_e = (a >= 32'h1000) || (a[1:0] != 2'b00) || (b == 4'h0);
      exp_rd = (!w && !exp_e) ? mref[d][a[5:2]] : 32'h0;
      if (w && !exp_e)
        for (int l = 0; l < 4; l++) if (b[l]) mref[d][a[5:2]][8*l +: 8] = wd[8*l +: 8];
      xfer(d, w, a, b, wd, lg, lr, rd, e, bad);
      tests_run++;
      if (e !== exp_e || rd !== exp_rd || lg !== gw_of[d] || lr !== lat_of[d] || bad !== 0) begin
        tests_failed++;
        $display("FAIL rand[%0d.%0d] we=%b addr=%h be=%b: err=%b rdata=%h lat_g=%0d lat_r=%0d bad=%0d, want %b %h %0d %0d 0",
                 d, t, w, a, b, e, rd, lg, lr, bad, exp_e, exp_rd, gw_of[d], lat_of[d]);
      end
    end
  endtask

  initial begin
    rst_n = 3'b000; req = 3'b111; we = 3'b000;
    for (int d = 0; d < 3; d++) begin addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'hF; end
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_gnt_wait();
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 15);
    test_random(2, 15);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
